at_req_sched: RTL and testbench



---
 rtl/at_req_sched_pkg.sv | 31 +++
 rtl/at_row_lock.sv | 56 +++++
 rtl/at_req_sched.sv | 216 +++++++++++++++++++++
 tb/tb_at_req_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/at_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// at_req_sched_pkg
// Shared definitions for the and-tree request scheduler:
//   - request size-type encodings (REQ_512 .. REQ_4K)
//   - and-tree index / request ID widths
//   - scheduler FSM state type
//   - default hazard window and starvation threshold
// -----------------------------------------------------------------------------
package at_req_sched_pkg;

    localparam int AT_TREE_INDEX_WIDTH = 6;   // 64 rows
    localparam int AT_TREE_COL_WIDTH   = 6;   // 64 bits per row
    localparam int REQ_ID_WIDTH        = 8;
    localparam int REQ_SIZE_WIDTH      = 2;

    // Cycles an issued update keeps its row locked (and-tree RMW depth).
    localparam int HAZ_WIN_DEFAULT     = 3;
    // Consecutive blocked alloc cycles before allocs take priority.
    localparam int STARVE_MAX_DEFAULT  = 4;

    localparam logic [REQ_SIZE_WIDTH-1:0] REQ_512 = 2'd0;
    localparam logic [REQ_SIZE_WIDTH-1:0] REQ_1K  = 2'd1;
    localparam logic [REQ_SIZE_WIDTH-1:0] REQ_2K  = 2'd2;
    localparam logic [REQ_SIZE_WIDTH-1:0] REQ_4K  = 2'd3;

    typedef enum logic {
        NORMAL     = 1'b0,
        ALLOC_PRIO = 1'b1
    } sched_state_e;

endpackage : at_req_sched_pkg

// File: rtl/at_row_lock.sv
// -----------------------------------------------------------------------------
// at_row_lock
// Shift register of {valid,row} entries recording rows recently written by
// the and-tree update path, plus a parallel compare against a query row.
// Entry 0 loads the push every cycle; every entry shifts by one each cycle,
// so a pushed row stays visible for exactly DEPTH cycles.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset (clears all entries)
//   push_valid_i in   row is being written this cycle
//   push_row_i   in   row being written
//   query_row_i  in   row to test against the table
//   hit_o        out  query row matches a valid entry (combinational)
// -----------------------------------------------------------------------------
module at_row_lock
    import at_req_sched_pkg::*;
#(
    parameter int ROW_W = AT_TREE_INDEX_WIDTH,
    parameter int DEPTH = HAZ_WIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [ROW_W-1:0] push_row_i,
    input  logic [ROW_W-1:0] query_row_i,
    output logic             hit_o
);

    logic [DEPTH-1:0] lock_v_q;
    logic [ROW_W-1:0] lock_row_q [DEPTH];
    logic [DEPTH-1:0] hit_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lock_v_q[i]   <= 1'b0;
                lock_row_q[i] <= '0;
            end
        end else begin
            lock_v_q[0]   <= push_valid_i;
            lock_row_q[0] <= push_row_i;
            for (int i = 1; i < DEPTH; i++) begin
                lock_v_q[i]   <= lock_v_q[i-1];
                lock_row_q[i] <= lock_row_q[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit_vec[gi] = lock_v_q[gi] && (lock_row_q[gi] == query_row_i);
    end

    assign hit_o = |hit_vec;

endmodule : at_row_lock

// File: rtl/at_req_sched.sv
// -----------------------------------------------------------------------------
// at_req_sched
// Scheduler in front of the and-tree. Accepts allocation searches (FDT) and
// bit updates (or-tree) on valid/ready handshakes and issues at most one of
// each per cycle through registered at_* outputs (1-cycle latency, 1-cycle
// pulse). Rows written by an issued update are locked so that searches do
// not read stale data and same-row updates are not lost in the and-tree's
// read-modify-write pipe. A starvation counter gives searches priority over
// same-row updates after STARVE_MAX consecutive blocked cycles.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alloc_valid_in / alloc_ready_out search request handshake
//   alloc_id_in, alloc_row_in, alloc_size_in   search payload
//   upd_valid_in / upd_ready_out     update request handshake
//   upd_row_in, upd_col_in, upd_bits_in         update payload
//   at_alloc_valid, at_alloc_id, at_alloc_pos, at_alloc_size  search issue
//   at_upd_en, at_upd_row, at_upd_col, at_upd_bits            update issue
//
// Optional build macro AT_SCHED_PERF_EN adds 32-bit saturating counters:
//   perf_alloc_stall   cycles with alloc valid && !ready
//   perf_upd_stall     cycles with upd valid && !ready
//   perf_prio_entries  NORMAL -> ALLOC_PRIO transitions
// -----------------------------------------------------------------------------
module at_req_sched
    import at_req_sched_pkg::*;
#(
    parameter int ROW_W      = AT_TREE_INDEX_WIDTH,
    parameter int COL_W      = AT_TREE_COL_WIDTH,
    parameter int ID_W       = REQ_ID_WIDTH,
    parameter int SIZE_W     = REQ_SIZE_WIDTH,
    parameter int HAZ_WIN    = HAZ_WIN_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid_in,
    output logic              alloc_ready_out,
    input  logic [ID_W-1:0]   alloc_id_in,
    input  logic [ROW_W-1:0]  alloc_row_in,
    input  logic [SIZE_W-1:0] alloc_size_in,
    input  logic              upd_valid_in,
    output logic              upd_ready_out,
    input  logic [ROW_W-1:0]  upd_row_in,
    input  logic [COL_W-1:0]  upd_col_in,
    input  logic [3:0]        upd_bits_in,
    output logic              at_alloc_valid,
    output logic [ID_W-1:0]   at_alloc_id,
    output logic [ROW_W-1:0]  at_alloc_pos,
    output logic [SIZE_W-1:0] at_alloc_size,
    output logic              at_upd_en,
    output logic [ROW_W-1:0]  at_upd_row,
    output logic [COL_W-1:0]  at_upd_col,
    output logic [3:0]        at_upd_bits
`ifdef AT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_alloc_stall,
    output logic [31:0]       perf_upd_stall,
    output logic [31:0]       perf_prio_entries
`endif
);

    localparam int                   STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]  STARVE_SAT = STARVE_W'(STARVE_MAX);

    sched_state_e        state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic alloc_lock_hit;
    logic upd_lock_hit;
    logic same_row;
    logic upd_fire;
    logic alloc_fire;
    logic alloc_stall;

    // Searches must not read a row until the update's write has fully
    // committed, so they see the whole HAZ_WIN window. A follow-on update
    // to the same row travels the same RMW pipe one stage behind, so it
    // only has to wait until the first update's write is in its last
    // stage: one entry fewer. Both tables are pushed identically.
    at_row_lock #(
        .ROW_W (ROW_W),
        .DEPTH (HAZ_WIN)
    ) u_alloc_lock (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (upd_fire),
        .push_row_i   (upd_row_in),
        .query_row_i  (alloc_row_in),
        .hit_o        (alloc_lock_hit)
    );

    at_row_lock #(
        .ROW_W (ROW_W),
        .DEPTH (HAZ_WIN - 1)
    ) u_upd_lock (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (upd_fire),
        .push_row_i   (upd_row_in),
        .query_row_i  (upd_row_in),
        .hit_o        (upd_lock_hit)
    );

    assign same_row = (upd_row_in == alloc_row_in);

    // In ALLOC_PRIO a pending same-row search blocks new updates so the
    // lock can drain; otherwise updates win the same-row tie.
    assign upd_ready_out = rst_n && !upd_lock_hit &&
                           !((state_q == ALLOC_PRIO) && alloc_valid_in && same_row);
    assign upd_fire      = upd_valid_in && upd_ready_out;

    // An update accepted this cycle locks its row immediately for searches.
    assign alloc_ready_out = rst_n && !alloc_lock_hit && !(upd_fire && same_row);
    assign alloc_fire      = alloc_valid_in && alloc_ready_out;
    assign alloc_stall     = alloc_valid_in && !alloc_ready_out;

    // Starvation counter and FSM next state.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;

        if (alloc_fire) begin
            starve_d = '0;
        end else if (alloc_stall && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        case (state_q)
            NORMAL: begin
                // Enter priority in the same cycle the counter saturates.
                if (starve_d == STARVE_SAT) begin
                    state_d = ALLOC_PRIO;
                end
            end
            ALLOC_PRIO: begin
                if (alloc_fire) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Issue registers: valid pulses for one cycle per accepted request;
    // payload only loads on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_alloc_valid <= 1'b0;
            at_alloc_id    <= '0;
            at_alloc_pos   <= '0;
            at_alloc_size  <= '0;
            at_upd_en      <= 1'b0;
            at_upd_row     <= '0;
            at_upd_col     <= '0;
            at_upd_bits    <= '0;
        end else begin
            at_alloc_valid <= alloc_fire;
            at_upd_en      <= upd_fire;
            if (alloc_fire) begin
                at_alloc_id   <= alloc_id_in;
                at_alloc_pos  <= alloc_row_in;
                at_alloc_size <= alloc_size_in;
            end
            if (upd_fire) begin
                at_upd_row  <= upd_row_in;
                at_upd_col  <= upd_col_in;
                at_upd_bits <= upd_bits_in;
            end
        end
    end

`ifdef AT_SCHED_PERF_EN
    logic [31:0] perf_alloc_stall_q;
    logic [31:0] perf_upd_stall_q;
    logic [31:0] perf_prio_entries_q;
    logic        upd_stall;
    logic        prio_enter;

    assign upd_stall  = upd_valid_in && !upd_ready_out;
    assign prio_enter = (state_q == NORMAL) && (state_d == ALLOC_PRIO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_alloc_stall_q  <= '0;
            perf_upd_stall_q    <= '0;
            perf_prio_entries_q <= '0;
        end else begin
            if (alloc_stall && (perf_alloc_stall_q != '1)) begin
                perf_alloc_stall_q <= perf_alloc_stall_q + 32'd1;
            end
            if (upd_stall && (perf_upd_stall_q != '1)) begin
                perf_upd_stall_q <= perf_upd_stall_q + 32'd1;
            end
            if (prio_enter && (perf_prio_entries_q != '1)) begin
                perf_prio_entries_q <= perf_prio_entries_q + 32'd1;
            end
        end
    end

    assign perf_alloc_stall  = perf_alloc_stall_q;
    assign perf_upd_stall    = perf_upd_stall_q;
    assign perf_prio_entries = perf_prio_entries_q;
`endif

endmodule : at_req_sched

// File: tb/tb_at_req_sched.sv
// -----------------------------------------------------------------------------
// tb_at_req_sched
// Directed scoreboard bench for at_req_sched. Stimulus pushes the expected
// issue (with its expected cycle) into a queue whenever it expects a
// request to be accepted; a forked monitor pops and compares whenever the
// DUT presents at_alloc_valid or at_upd_en.
// -----------------------------------------------------------------------------
module tb_at_req_sched;
    import at_req_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid_in;
    logic       alloc_ready_out;
    logic [7:0] alloc_id_in;
    logic [5:0] alloc_row_in;
    logic [1:0] alloc_size_in;
    logic       upd_valid_in;
    logic       upd_ready_out;
    logic [5:0] upd_row_in;
    logic [5:0] upd_col_in;
    logic [3:0] upd_bits_in;
    logic       at_alloc_valid;
    logic [7:0] at_alloc_id;
    logic [5:0] at_alloc_pos;
    logic [1:0] at_alloc_size;
    logic       at_upd_en;
    logic [5:0] at_upd_row;
    logic [5:0] at_upd_col;
    logic [3:0] at_upd_bits;
`ifdef AT_SCHED_PERF_EN
    logic [31:0] perf_alloc_stall;
    logic [31:0] perf_upd_stall;
    logic [31:0] perf_prio_entries;
`endif

    at_req_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid_in  (alloc_valid_in),
        .alloc_ready_out (alloc_ready_out),
        .alloc_id_in     (alloc_id_in),
        .alloc_row_in    (alloc_row_in),
        .alloc_size_in   (alloc_size_in),
        .upd_valid_in    (upd_valid_in),
        .upd_ready_out   (upd_ready_out),
        .upd_row_in      (upd_row_in),
        .upd_col_in      (upd_col_in),
        .upd_bits_in     (upd_bits_in),
        .at_alloc_valid  (at_alloc_valid),
        .at_alloc_id     (at_alloc_id),
        .at_alloc_pos    (at_alloc_pos),
        .at_alloc_size   (at_alloc_size),
        .at_upd_en       (at_upd_en),
        .at_upd_row      (at_upd_row),
        .at_upd_col      (at_upd_col),
        .at_upd_bits     (at_upd_bits)
`ifdef AT_SCHED_PERF_EN
        ,
        .perf_alloc_stall  (perf_alloc_stall),
        .perf_upd_stall    (perf_upd_stall),
        .perf_prio_entries (perf_prio_entries)
`endif
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  id;
        logic [5:0]  pos;
        logic [1:0]  size;
    } alloc_exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  row;
        logic [5:0]  col;
        logic [3:0]  bits;
    } upd_exp_t;

    alloc_exp_t aq[$];
    upd_exp_t   uq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // One cycle of stimulus: drive inputs, check readies mid-cycle, and
    // enqueue the issues expected next cycle.
    task automatic step(input logic av, input logic [7:0] aid, input logic [5:0] arow,
                        input logic [1:0] asz, input logic uv, input logic [5:0] urow,
                        input logic [5:0] ucol, input logic [3:0] ubits,
                        input logic ear, input logic eur, input string tag);
        alloc_valid_in = av;
        alloc_id_in    = aid;
        alloc_row_in   = arow;
        alloc_size_in  = asz;
        upd_valid_in   = uv;
        upd_row_in     = urow;
        upd_col_in     = ucol;
        upd_bits_in    = ubits;
        @(negedge clk);
        if (av) chk({tag, "_alloc_ready"}, 64'(alloc_ready_out), 64'(ear));
        if (uv) chk({tag, "_upd_ready"}, 64'(upd_ready_out), 64'(eur));
        if (av && ear) aq.push_back('{cyc: 32'(cyc + 1), id: aid, pos: arow, size: asz});
        if (uv && eur) uq.push_back('{cyc: 32'(cyc + 1), row: urow, col: ucol, bits: ubits});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h0, 6'd0, 2'd0, 1'b0, 6'd0, 6'd0, 4'd0, 1'b0, 1'b0, "idle");
        end
    endtask

    task automatic monitor();
        alloc_exp_t ae;
        upd_exp_t   ue;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (at_alloc_valid) begin
                    if (aq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL alloc_unexpected actual pos=%0d id=%0h required no issue (cycle %0d)",
                                 at_alloc_pos, at_alloc_id, cyc);
                    end else begin
                        ae = aq.pop_front();
                        chk("alloc_cycle", 64'(cyc), 64'(ae.cyc));
                        chk("alloc_id", 64'(at_alloc_id), 64'(ae.id));
                        chk("alloc_pos", 64'(at_alloc_pos), 64'(ae.pos));
                        chk("alloc_size", 64'(at_alloc_size), 64'(ae.size));
                        $display("cycle %0d alloc issue id=%0h pos=%0d size=%0d",
                                 cyc, at_alloc_id, at_alloc_pos, at_alloc_size);
                    end
                end
                if (at_upd_en) begin
                    if (uq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL upd_unexpected actual row=%0d bits=%0h required no issue (cycle %0d)",
                                 at_upd_row, at_upd_bits, cyc);
                    end else begin
                        ue = uq.pop_front();
                        chk("upd_cycle", 64'(cyc), 64'(ue.cyc));
                        chk("upd_row", 64'(at_upd_row), 64'(ue.row));
                        chk("upd_col", 64'(at_upd_col), 64'(ue.col));
                        chk("upd_bits", 64'(at_upd_bits), 64'(ue.bits));
                        $display("cycle %0d upd issue row=%0d col=%0d bits=%b",
                                 cyc, at_upd_row, at_upd_col, at_upd_bits);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        alloc_valid_in = 1'b0;
        alloc_id_in    = '0;
        alloc_row_in   = '0;
        alloc_size_in  = '0;
        upd_valid_in   = 1'b0;
        upd_row_in     = '0;
        upd_col_in     = '0;
        upd_bits_in    = '0;

        fork
            monitor();
        join_none

        // Reset state: outputs zero, readies held low.
        repeat (2) @(posedge clk);
        #1;
        alloc_valid_in = 1'b1;
        upd_valid_in   = 1'b1;
        #1;
        chk("reset_alloc_ready", 64'(alloc_ready_out), 64'(0));
        chk("reset_upd_ready", 64'(upd_ready_out), 64'(0));
        chk("reset_at_alloc_valid", 64'(at_alloc_valid), 64'(0));
        chk("reset_at_upd_en", 64'(at_upd_en), 64'(0));
        chk("reset_at_alloc_pos", 64'(at_alloc_pos), 64'(0));
        chk("reset_at_upd_bits", 64'(at_upd_bits), 64'(0));
        alloc_valid_in = 1'b0;
        upd_valid_in   = 1'b0;
        rst_n          = 1'b1;
        @(posedge clk);
        #1;

        // Starvation: alloc row 2 held, continuous updates to row 2.
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0001, 0, 1, "starve_c0");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0011, 0, 0, "starve_c1");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0011, 0, 0, "starve_c2");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0011, 0, 1, "starve_c3");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0111, 0, 0, "starve_c4");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0111, 0, 0, "starve_c5");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0111, 0, 0, "starve_c6_prio");
        step(1, 8'h44, 6'd2, REQ_512, 1, 6'd2, 6'd10, 4'b0111, 1, 0, "starve_c7_prio");
        step(0, 8'h00, 6'd0, REQ_512, 1, 6'd2, 6'd10, 4'b0111, 0, 1, "starve_c8_normal");
        idle(4);
`ifdef AT_SCHED_PERF_EN
        chk("perf_alloc_stall", 64'(perf_alloc_stall), 64'(7));
        chk("perf_upd_stall", 64'(perf_upd_stall), 64'(6));
        chk("perf_prio_entries", 64'(perf_prio_entries), 64'(1));
`endif

        // Independent traffic: different rows, both accepted.
        step(1, 8'h11, 6'd5, REQ_1K, 1, 6'd9, 6'd33, 4'b1010, 1, 1, "indep");
        idle(4);

        // Same-row tie: update wins, search waits out the lock window.
        step(1, 8'h22, 6'd3, REQ_4K, 1, 6'd3, 6'd63, 4'b0001, 0, 1, "tie_c0");
        step(1, 8'h22, 6'd3, REQ_4K, 0, 6'd0, 6'd0, 4'b0000, 0, 0, "tie_c1");
        step(1, 8'h22, 6'd3, REQ_4K, 0, 6'd0, 6'd0, 4'b0000, 0, 0, "tie_c2");
        step(1, 8'h22, 6'd3, REQ_4K, 0, 6'd0, 6'd0, 4'b0000, 0, 0, "tie_c3");
        step(1, 8'h22, 6'd3, REQ_4K, 0, 6'd0, 6'd0, 4'b0000, 1, 0, "tie_c4");
        idle(4);

        // Back-to-back updates to row 7.
        step(0, 8'h00, 6'd0, REQ_512, 1, 6'd7, 6'd1, 4'b0101, 0, 1, "b2b_c0");
        step(0, 8'h00, 6'd0, REQ_512, 1, 6'd7, 6'd2, 4'b1100, 0, 0, "b2b_c1");
        step(0, 8'h00, 6'd0, REQ_512, 1, 6'd7, 6'd2, 4'b1100, 0, 0, "b2b_c2");
        step(0, 8'h00, 6'd0, REQ_512, 1, 6'd7, 6'd2, 4'b1100, 0, 1, "b2b_c3");
        idle(4);

        // Reset during an update issue.
        upd_valid_in = 1'b1;
        upd_row_in   = 6'd12;
        upd_col_in   = 6'd5;
        upd_bits_in  = 4'b0110;
        @(negedge clk);
        chk("rst_upd_ready", 64'(upd_ready_out), 64'(1));
        @(posedge clk);
        #1;
        upd_valid_in = 1'b0;
        chk("rst_issue_en", 64'(at_upd_en), 64'(1));
        chk("rst_issue_row", 64'(at_upd_row), 64'(12));
        rst_n          = 1'b0;
        alloc_valid_in = 1'b1;
        alloc_row_in   = 6'd12;
        #1;
        chk("rst_mid_at_upd_en", 64'(at_upd_en), 64'(0));
        chk("rst_mid_at_upd_row", 64'(at_upd_row), 64'(0));
        chk("rst_mid_at_upd_bits", 64'(at_upd_bits), 64'(0));
        chk("rst_mid_at_alloc_valid", 64'(at_alloc_valid), 64'(0));
        chk("rst_mid_alloc_ready", 64'(alloc_ready_out), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 8'h55, 6'd12, REQ_2K, 0, 6'd0, 6'd0, 4'b0000, 1, 0, "rst_release");
        idle(6);

        chk("alloc_queue_empty", 64'(aq.size()), 64'(0));
        chk("upd_queue_empty", 64'(uq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_at_req_sched
